// File: rtl/ysyx_23060278_pkg.sv
// Shared definitions for the ysyx_23060278 core.
// Holds the data width, the IFU reset vector, the IFU state encoding and the
// RV32 major opcodes that the fetch, decode and execute stages have in common.
package ysyx_23060278_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // IFU state encoding
  localparam logic [2:0] IFU_IDLE = 3'd0;
  localparam logic [2:0] IFU_REQ  = 3'd1;
  localparam logic [2:0] IFU_WAIT = 3'd2;
  localparam logic [2:0] IFU_OUT  = 3'd3;
  localparam logic [2:0] IFU_ERR  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = IFU_IDLE,
    ST_REQ  = IFU_REQ,
    ST_WAIT = IFU_WAIT,
    ST_OUT  = IFU_OUT,
    ST_ERR  = IFU_ERR
  } ifu_state_e;

  // RV32 major opcodes (inst[6:0])
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060278_ifu_if.sv
// Instruction memory port between the fetch unit and instruction memory.
//   imem_req_valid  : request valid (master -> slave)
//   imem_req_ready  : request accepted this cycle (slave -> master)
//   imem_addr       : word fetch address (master -> slave)
//   imem_resp_valid : one-cycle pulse per accepted request (slave -> master)
//   imem_resp_data  : instruction word (slave -> master)
interface ysyx_23060278_ifu_if;
  import ysyx_23060278_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit.
// Holds the PC, issues one word request at a time on the imem port, registers
// the returned word and offers it with its PC to the decoder over a
// valid/ready handshake. Redirects from execute are accepted in any state; a
// response already in flight when a redirect arrives is dropped (discard).
// A misaligned redirect target parks the unit in ERR until an aligned one.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem             : instruction memory port (master side)
//   inst_valid/ready : handshake to decoder, inst / inst_pc carry the payload
//   redirect_valid/pc: next-PC override from execute
//   misalign         : sticky, last redirect target not word aligned
module ysyx_23060278_ifu
  import ysyx_23060278_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_23060278_ifu_if.master        imem,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       misalign
);

  ifu_state_e      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] inst_pc_n;
  logic [31:0]     inst_n;
  logic            discard, discard_n;
  logic            misalign_n;
  logic            redir_bad;

  assign redir_bad = !word_aligned(redirect_pc);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  // NOTE: the instruction buffer is a plain register, not a memory, so it is
  // reset like the rest of the state and never shows X to the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      inst     <= '0;
      inst_pc  <= '0;
      discard  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inst     <= inst_n;
      inst_pc  <= inst_pc_n;
      discard  <= discard_n;
      misalign <= misalign_n;
    end
  end

  // misalign doubles as the "go to ERR after the stale response" marker, so
  // every redirect rewrites it and the drain of a discarded response picks
  // ERR or REQ from it.
  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    discard_n  = discard;
    misalign_n = misalign;

    case (state)
      ST_IDLE, ST_OUT: begin
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          misalign_n = redir_bad;
          state_n    = redir_bad ? ST_ERR : ST_REQ;
        end else if (state == ST_IDLE) begin
          state_n = ST_REQ;
        end else if (inst_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = ST_REQ;
        end
      end

      ST_REQ: begin
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          misalign_n = redir_bad;
          if (imem.imem_req_ready) begin
            // Request went out with the old PC; its answer must be dropped.
            discard_n = 1'b1;
            state_n   = ST_WAIT;
          end else begin
            state_n = redir_bad ? ST_ERR : ST_REQ;
          end
        end else if (imem.imem_req_ready) begin
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          misalign_n = redir_bad;
          if (imem.imem_resp_valid) begin
            discard_n = 1'b0;
            state_n   = redir_bad ? ST_ERR : ST_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (imem.imem_resp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = misalign ? ST_ERR : ST_REQ;
          end else begin
            inst_n    = imem.imem_resp_data;
            inst_pc_n = pc;
            state_n   = ST_OUT;
          end
        end
      end

      ST_ERR: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (!redir_bad) begin
            misalign_n = 1'b0;
            state_n    = ST_REQ;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign imem.imem_req_valid = (state == ST_REQ);
  assign imem.imem_addr      = pc;
  assign inst_valid          = (state == ST_OUT) && !discard;

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
module tb_ysyx_23060278_ifu;
  import ysyx_23060278_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  ysyx_23060278_ifu_if imem ();

  ysyx_23060278_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem.master),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_tick(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Starting in REQ: accept, respond one cycle later, land in OUT.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
    checks++; if (imem.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_req_valid got=%b want=1", imem.imem_req_valid); end
    checks++; if (imem.imem_addr !== exp_addr) begin errors++; $display("FAIL fetch_addr got=%h want=%h", imem.imem_addr, exp_addr); end
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    checks++; if (imem.imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait req=%b inst_valid=%b want 0/0", imem.imem_req_valid, inst_valid); end
    imem.imem_resp_valid = 1'b1;
    imem.imem_resp_data  = data;
    tick();
    imem.imem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_inst_valid got=%b want=1", inst_valid); end
    checks++; if (inst !== data) begin errors++; $display("FAIL fetch_inst got=%h want=%h", inst, data); end
    checks++; if (inst_pc !== exp_addr) begin errors++; $display("FAIL fetch_inst_pc got=%h want=%h", inst_pc, exp_addr); end
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem.imem_req_ready = 1'b0; imem.imem_resp_valid = 1'b0; imem.imem_resp_data = '0;
    tick(); tick();
    checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b want=0", imem.imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    checks++; if (imem.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got=%h want=80000000", imem.imem_addr); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h/%h want=0/0", inst, inst_pc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b want=0", misalign); end
    rst_n = 1'b1;
    checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got=%b want=0", imem.imem_req_valid); end
    tick();
  endtask

  task automatic test_basic();
    fetch_one(32'h8000_0000, 32'h0000_0013);
    consume();
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_next got=%b/%h want=1/80000004", imem.imem_req_valid, imem.imem_addr); end
  endtask

  task automatic test_backpressure();
    fetch_one(32'h8000_0004, 32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 || imem.imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] v=%b inst=%h pc=%h req=%b want 1/00100093/80000004/0", i, inst_valid, inst, inst_pc, imem.imem_req_valid);
      end
    end
    consume();
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL bp_next got=%b/%h want=1/80000008", imem.imem_req_valid, imem.imem_addr); end
    tick();
    checks++; if (imem.imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL bp_single_inc got=%h want=80000008", imem.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    redirect_tick(32'h8000_1000);
    checks++; if (imem.imem_req_valid !== 1'b0 || imem.imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_wait got=%b/%h want=0/80001000", imem.imem_req_valid, imem.imem_addr); end
    imem.imem_resp_valid = 1'b1;
    imem.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem.imem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_stale v=%b inst=%h want v=0 and not deadbeef", inst_valid, inst); end
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_refetch got=%b/%h want=1/80001000", imem.imem_req_valid, imem.imem_addr); end
    fetch_one(32'h8000_1000, 32'h0000_0297);
  endtask

  task automatic test_redirect_out();
    inst_ready = 1'b1;
    redirect_tick(32'h8000_0100);
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ro_drop got=%b want=0", inst_valid); end
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL ro_addr got=%b/%h want=1/80000100", imem.imem_req_valid, imem.imem_addr); end
  endtask

  task automatic test_misalign();
    redirect_tick(32'h8000_0102);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set got=%b want=1", misalign); end
    checks++; if (imem.imem_addr !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc got=%h want=80000102", imem.imem_addr); end
    imem.imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem.imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_err[%0d] req=%b v=%b want 0/0", i, imem.imem_req_valid, inst_valid); end
      tick();
    end
    imem.imem_req_ready = 1'b0;
    redirect_tick(32'h8000_0200);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b want=0", misalign); end
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL mis_exit got=%b/%h want=1/80000200", imem.imem_req_valid, imem.imem_addr); end
    // Misaligned redirect with a request in flight: drain, then ERR.
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    redirect_tick(32'h8000_0306);
    checks++; if (misalign !== 1'b1 || imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL misw_set got=%b/%b want=1/0", misalign, imem.imem_req_valid); end
    imem.imem_resp_valid = 1'b1;
    imem.imem_resp_data  = 32'h1234_5678;
    tick();
    imem.imem_resp_valid = 1'b0;
    checks++; if (imem.imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign !== 1'b1) begin errors++; $display("FAIL misw_err req=%b v=%b mis=%b want 0/0/1", imem.imem_req_valid, inst_valid, misalign); end
    tick();
    checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL misw_hold got=%b want=0", imem.imem_req_valid); end
    redirect_tick(32'h8000_0300);
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0300 || misalign !== 1'b0) begin errors++; $display("FAIL misw_exit got=%b/%h/%b want=1/80000300/0", imem.imem_req_valid, imem.imem_addr, misalign); end
  endtask

  task automatic test_wrap();
    redirect_tick(32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0013);
    consume();
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap got=%b/%h want=1/00000000", imem.imem_req_valid, imem.imem_addr); end
  endtask

  task automatic test_async_reset();
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem.imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL areset_valid req=%b v=%b want 0/0", imem.imem_req_valid, inst_valid); end
    checks++; if (imem.imem_addr !== 32'h8000_0000 || inst !== 32'h0 || inst_pc !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL areset_regs addr=%h inst=%h pc=%h mis=%b want 80000000/0/0/0", imem.imem_addr, inst, inst_pc, misalign); end
    imem.imem_resp_valid = 1'b1;
    imem.imem_resp_data  = 32'hCAFE_F00D;
    tick();
    rst_n = 1'b1;
    tick();
    imem.imem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL areset_late_resp v=%b inst=%h want 0/0", inst_valid, inst); end
    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL areset_restart got=%b/%h want=1/80000000", imem.imem_req_valid, imem.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
